// File: rtl/execute_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv_pkg
// Description : Shared types for the execute-stage multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package execute_muldiv_pkg;

    localparam int WORD_WIDTH = 32;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } md_state_t;

    function automatic logic isSignedOp(input md_op_t op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_div_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_div_step
// Description : One combinational restoring-division step (one quotient bit).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] remIn,
    input  logic [WIDTH-1:0] quoIn,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] remOut,
    output logic [WIDTH-1:0] quoOut
);

    logic [WIDTH:0] w_trial;
    logic [WIDTH:0] w_diff;

    // Partial remainder stays below the divisor, so the shifted trial fits WIDTH+1 bits.
    assign w_trial = {remIn, quoIn[WIDTH-1]};
    assign w_diff  = w_trial - {1'b0, divisor};

    assign remOut = w_diff[WIDTH] ? w_trial[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign quoOut = {quoIn[WIDTH-2:0], ~w_diff[WIDTH]};

endmodule
`default_nettype wire

// File: rtl/execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : execute_muldiv
// Description : Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO and MTHI/MTLO.
// Revision    : 1.0 - initial release
// ============================================================================
module execute_muldiv
    import execute_muldiv_pkg::*;
#(
    parameter int WIDTH      = WORD_WIDTH,
    parameter int MUL_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  md_op_t           op_i,
    input  logic [WIDTH-1:0] srca_i,
    input  logic [WIDTH-1:0] srcb_i,
    input  logic             flush_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int c_CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD = c_CNT_W'(WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    md_state_t          r_state;
    md_state_t          w_stateNext;
    logic [c_CNT_W-1:0] r_cnt;
    logic [2*WIDTH-1:0] r_mulA;
    logic [2*WIDTH-1:0] r_mulB;
    logic [2*WIDTH-1:0] w_product;
    logic [2*WIDTH-1:0] w_mulResult;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_divisor;
    logic [WIDTH-1:0]   w_remNext;
    logic [WIDTH-1:0]   w_quoNext;
    logic               r_negQ;
    logic               r_negR;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_accept;
    logic               w_signedOp;
    logic               w_isMul;
    logic               w_isDiv;
    logic               w_cntZero;
    logic               w_hiWe;
    logic               w_loWe;
    logic [WIDTH-1:0]   w_hiNext;
    logic [WIDTH-1:0]   w_loNext;
    logic [WIDTH-1:0]   w_magA;
    logic [WIDTH-1:0]   w_magB;
    logic [WIDTH-1:0]   w_quoFixed;
    logic [WIDTH-1:0]   w_remFixed;

    assign w_accept   = start_i && !flush_i && (r_state == ST_IDLE);
    assign w_signedOp = isSignedOp(op_i);
    assign w_isMul    = (op_i == MD_MULT) || (op_i == MD_MULTU);
    assign w_isDiv    = (op_i == MD_DIV)  || (op_i == MD_DIVU);
    assign w_cntZero  = (r_cnt == '0);

    // MIN_INT negates to itself, which is exactly its unsigned magnitude.
    assign w_magA = (w_signedOp && srca_i[WIDTH-1]) ? -srca_i : srca_i;
    assign w_magB = (w_signedOp && srcb_i[WIDTH-1]) ? -srcb_i : srcb_i;

    assign w_quoFixed = r_negQ ? -r_quo : r_quo;
    assign w_remFixed = r_negR ? -r_rem : r_rem;

    // Operands are pre-extended to 2*WIDTH, so the low half of one product serves both signednesses.
    assign w_product = r_mulA * r_mulB;

    generate
        if (MUL_CYCLES > 1) begin : g_mulPipe
            logic [2*WIDTH-1:0] r_pipe [MUL_CYCLES-1];

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < MUL_CYCLES - 1; i++) begin
                        r_pipe[i] <= '0;
                    end
                end else begin
                    r_pipe[0] <= w_product;
                    for (int i = 1; i < MUL_CYCLES - 1; i++) begin
                        r_pipe[i] <= r_pipe[i-1];
                    end
                end
            end

            assign w_mulResult = r_pipe[MUL_CYCLES-2];
        end else begin : g_mulDirect
            assign w_mulResult = w_product;
        end
    endgenerate

    muldiv_div_step #(
        .WIDTH (WIDTH)
    ) u_divStep (
        .remIn   (r_rem),
        .quoIn   (r_quo),
        .divisor (r_divisor),
        .remOut  (w_remNext),
        .quoOut  (w_quoNext)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_isMul) begin
                    w_stateNext = ST_MUL;
                end else if (w_accept && w_isDiv) begin
                    w_stateNext = ST_DIV;
                end
            end
            ST_MUL: begin
                if (flush_i || w_cntZero) begin
                    w_stateNext = ST_IDLE;
                end
            end
            ST_DIV: begin
                if (flush_i) begin
                    w_stateNext = ST_IDLE;
                end else if (w_cntZero) begin
                    w_stateNext = ST_FIX;
                end
            end
            ST_FIX: begin
                w_stateNext = ST_IDLE;
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Flush suppresses every HI/LO write, including a completing one.
    always_comb begin
        busy_o   = (r_state != ST_IDLE);
        w_hiWe   = 1'b0;
        w_loWe   = 1'b0;
        w_hiNext = r_hi;
        w_loNext = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && (op_i == MD_MTHI)) begin
                    w_hiWe   = 1'b1;
                    w_hiNext = srca_i;
                end
                if (w_accept && (op_i == MD_MTLO)) begin
                    w_loWe   = 1'b1;
                    w_loNext = srca_i;
                end
            end
            ST_MUL: begin
                if (w_cntZero && !flush_i) begin
                    w_hiWe   = 1'b1;
                    w_loWe   = 1'b1;
                    w_hiNext = w_mulResult[2*WIDTH-1:WIDTH];
                    w_loNext = w_mulResult[WIDTH-1:0];
                end
            end
            ST_FIX: begin
                if (!flush_i) begin
                    w_hiWe   = 1'b1;
                    w_loWe   = 1'b1;
                    w_hiNext = w_remFixed;
                    w_loNext = w_quoFixed;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_mulA    <= '0;
            r_mulB    <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_negQ    <= 1'b0;
            r_negR    <= 1'b0;
        end else if (w_accept && w_isMul) begin
            r_mulA <= w_signedOp ? {{WIDTH{srca_i[WIDTH-1]}}, srca_i} : {{WIDTH{1'b0}}, srca_i};
            r_mulB <= w_signedOp ? {{WIDTH{srcb_i[WIDTH-1]}}, srcb_i} : {{WIDTH{1'b0}}, srcb_i};
            r_cnt  <= c_MUL_LOAD;
        end else if (w_accept && w_isDiv) begin
            r_rem     <= '0;
            r_quo     <= w_magA;
            r_divisor <= w_magB;
            r_negQ    <= w_signedOp && (srca_i[WIDTH-1] ^ srcb_i[WIDTH-1]);
            r_negR    <= w_signedOp && srca_i[WIDTH-1];
            r_cnt     <= c_DIV_LOAD;
        end else if ((r_state == ST_MUL) || (r_state == ST_DIV)) begin
            if (r_state == ST_DIV) begin
                r_rem <= w_remNext;
                r_quo <= w_quoNext;
            end
            if (!w_cntZero) begin
                r_cnt <= r_cnt - c_CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else begin
            if (w_hiWe) begin
                r_hi <= w_hiNext;
            end
            if (w_loWe) begin
                r_lo <= w_loNext;
            end
        end
    end

    assign hi_o = r_hi;
    assign lo_o = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_execute_muldiv.sv
`default_nettype none
// ============================================================================
// Module      : tb_execute_muldiv
// Description : Directed vector table plus corner sequences for execute_muldiv.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_muldiv;
    import execute_muldiv_pkg::*;

    logic        clk;
    logic        reset;
    logic        start;
    md_op_t      op;
    logic [31:0] srca;
    logic [31:0] srcb;
    logic        flush;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int nChecks = 0;
    int nErrors = 0;

    typedef struct {
        md_op_t      op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expHi;
        logic [31:0] expLo;
        int          expBusy;
    } vec_t;

    vec_t vecs[15];

    execute_muldiv #(
        .WIDTH      (32),
        .MUL_CYCLES (3)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start_i (start),
        .op_i    (op),
        .srca_i  (srca),
        .srcb_i  (srcb),
        .flush_i (flush),
        .busy_o  (busy),
        .hi_o    (hi),
        .lo_o    (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle(output int cycles);
        cycles = 0;
        while (busy && cycles < 200) begin
            cycles++;
            tick();
        end
    endtask

    task automatic issue(input md_op_t o, input logic [31:0] a, input logic [31:0] b, output int cycles);
        start = 1'b1;
        op    = o;
        srca  = a;
        srcb  = b;
        tick();
        start = 1'b0;
        waitIdle(cycles);
    endtask

    initial begin
        int n;

        vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 3};
        vecs[1]  = '{MD_MULTU, 32'hFFFFFFFE, 32'h00000003, 32'h00000002, 32'hFFFFFFFA, 3};
        vecs[2]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3]  = '{MD_DIVU,  32'h00000007, 32'h00000002, 32'h00000001, 32'h00000003, 33};
        vecs[4]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33};
        vecs[5]  = '{MD_DIVU,  32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 33};
        vecs[6]  = '{MD_MTHI,  32'h00000011, 32'h00000000, 32'h00000011, 32'hFFFFFFFF, 0};
        vecs[7]  = '{MD_MTLO,  32'h00000022, 32'h00000000, 32'h00000011, 32'h00000022, 0};
        vecs[8]  = '{MD_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33};
        vecs[9]  = '{MD_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'h00000001, 33};
        vecs[10] = '{MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 3};
        vecs[11] = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 3};
        vecs[12] = '{MD_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 3};
        vecs[13] = '{MD_DIVU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 33};
        vecs[14] = '{MD_DIV,   32'h00000064, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFF2, 33};

        reset = 1'b1;
        start = 1'b0;
        op    = MD_MULT;
        srca  = '0;
        srcb  = '0;
        flush = 1'b0;
        tick();
        tick();
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_hi", hi, 32'h0);
        check("reset_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 15; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, n);
            check($sformatf("vec%0d_busy_cycles", i), n, vecs[i].expBusy);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].expHi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].expLo);
        end

        // Second MULT held on start_i during the first must wait for idle.
        start = 1'b1;
        op    = MD_MULT;
        srca  = 32'd2;
        srcb  = 32'd3;
        tick();
        srca  = 32'd4;
        srcb  = 32'd5;
        waitIdle(n);
        check("held_first_busy", n, 3);
        check("held_first_lo", lo, 32'd6);
        check("held_first_hi", hi, 32'd0);
        tick();
        check("held_second_accepted", {31'b0, busy}, 32'h1);
        start = 1'b0;
        waitIdle(n);
        check("held_second_busy", n, 3);
        check("held_second_lo", lo, 32'd20);

        // Flush in DIV cycle 20 discards the divide.
        issue(MD_MTHI, 32'h11, 32'h0, n);
        issue(MD_MTLO, 32'h22, 32'h0, n);
        start = 1'b1;
        op    = MD_DIV;
        srca  = 32'd100;
        srcb  = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 20; i++) tick();
        check("div_c20_busy", {31'b0, busy}, 32'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("div_flush_busy", {31'b0, busy}, 32'h0);
        check("div_flush_hi", hi, 32'h11);
        check("div_flush_lo", lo, 32'h22);
        for (int i = 0; i < 40; i++) tick();
        check("div_flush_late_hi", hi, 32'h11);
        check("div_flush_late_lo", lo, 32'h22);

        // Flush together with start: nothing accepted.
        start = 1'b1;
        flush = 1'b1;
        op    = MD_MTHI;
        srca  = 32'h99;
        tick();
        check("flush_mthi_hi", hi, 32'h11);
        op    = MD_MULT;
        tick();
        start = 1'b0;
        flush = 1'b0;
        check("flush_mult_busy", {31'b0, busy}, 32'h0);

        // Flush on the completing MUL cycle beats the HI/LO write.
        start = 1'b1;
        op    = MD_MULT;
        srca  = 32'd3;
        srcb  = 32'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("mul_lastflush_busy", {31'b0, busy}, 32'h0);
        check("mul_lastflush_hi", hi, 32'h11);
        check("mul_lastflush_lo", lo, 32'h22);

        // Asynchronous reset in DIV cycle 10.
        start = 1'b1;
        op    = MD_DIV;
        srca  = 32'd100;
        srcb  = 32'd7;
        tick();
        start = 1'b0;
        for (int i = 1; i < 10; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        check("areset_busy", {31'b0, busy}, 32'h0);
        check("areset_hi", hi, 32'h0);
        check("areset_lo", lo, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        start = 1'b1;
        op    = MD_MTLO;
        srca  = 32'h5;
        #1;
        check("mtlo_before_edge", lo, 32'h0);
        tick();
        start = 1'b0;
        check("mtlo_lo", lo, 32'h5);
        check("mtlo_hi", hi, 32'h0);
        check("mtlo_busy", {31'b0, busy}, 32'h0);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
